adsr_poly: RTL

Parametrised, multi-channel successor to the single-voice ADSR envelope generator. Runs entirely on the system clock: the separate attack/decay/release clocks are replaced by internal programmable rate dividers. Each of `CHANNELS` voices has an independent envelope state machine and scales its own unsigned sample by the envelope. Sits between the per-voice oscillators and the voice mixer.

---
 rtl/adsr_poly.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/adsr_poly.sv
// adsr_poly: multi-channel ADSR envelope generator running on the system clock.
// Each channel owns an envelope state machine, an envelope register and a
// programmable tick divider, and scales its own unsigned sample by the envelope.
// Rate and sustain controls are shared and sampled by every channel each cycle.

module adsr_poly #(
    parameter int CHANNELS    = 4,
    parameter int DATA_W      = 16,
    parameter int ENV_W       = 8,
    parameter int RATE_W      = 16,
    parameter bit RETRIG_ZERO = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 note_on,
    input  logic [RATE_W-1:0]                   attack_rate,
    input  logic [RATE_W-1:0]                   decay_rate,
    input  logic [RATE_W-1:0]                   release_rate,
    input  logic [ENV_W-1:0]                    sustain_level,
    input  logic [CHANNELS*DATA_W-1:0]          in,
    output logic [CHANNELS*(DATA_W+ENV_W)-1:0]  signal_out,
    output logic [CHANNELS*ENV_W-1:0]           env_out,
    output logic [CHANNELS-1:0]                 active
);

    localparam int                PROD_W  = DATA_W + ENV_W;
    localparam logic [ENV_W-1:0]  ENV_MAX = '1;
    localparam logic [ENV_W-1:0]  ENV_ONE = {{(ENV_W-1){1'b0}}, 1'b1};
    localparam logic [RATE_W-1:0] CNT_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_e;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch

        state_e              state_q, state_d;
        logic [ENV_W-1:0]    env_q, env_d;
        logic [RATE_W-1:0]   cnt_q, cnt_d;
        logic [PROD_W-1:0]   prod_q, prod_d;
        logic [RATE_W-1:0]   rate;
        logic                counting;
        logic                tick;
        logic                gate;
        logic [PROD_W-1:0]   sample_ext;
        logic [PROD_W-1:0]   env_ext;

        assign gate = note_on[k];

        // Pick the divider rate of the current phase and detect its tick.
        // NOTE: every variable written in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        always_comb begin
            rate     = attack_rate;
            counting = 1'b0;
            case (state_q)
                ST_ATTACK: begin
                    rate     = attack_rate;
                    counting = 1'b1;
                end
                ST_DECAY: begin
                    rate     = decay_rate;
                    counting = 1'b1;
                end
                ST_RELEASE: begin
                    rate     = release_rate;
                    counting = 1'b1;
                end
                default: begin
                    rate     = attack_rate;
                    counting = 1'b0;
                end
            endcase
            tick = counting && (cnt_q == rate);
        end

        // Envelope state machine: next state and next envelope level.
        // A released gate wins over a same-cycle tick in every sounding phase.
        always_comb begin
            state_d = state_q;
            env_d   = env_q;
            case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                    if (gate) begin
                        state_d = ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (env_q == ENV_MAX) begin
                        // Retriggered at full scale: nothing left to climb.
                        state_d = ST_DECAY;
                    end else if (tick) begin
                        env_d = env_q + ENV_ONE;
                        if (env_d == ENV_MAX) begin
                            state_d = ST_DECAY;
                        end
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else if (env_q <= sustain_level) begin
                        state_d = ST_SUSTAIN;
                    end else if (tick) begin
                        env_d = env_q - ENV_ONE;
                        if (env_d == sustain_level) begin
                            state_d = ST_SUSTAIN;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                    end else begin
                        env_d = sustain_level;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        state_d = ST_ATTACK;
                        if (RETRIG_ZERO) begin
                            env_d = '0;
                        end
                    end else if (env_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        env_d = env_q - ENV_ONE;
                        if (env_d == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    env_d   = '0;
                end
            endcase
        end

        // Tick divider: counts in timed phases, clears on tick and on any state change.
        // A counter already above a freshly lowered rate simply wraps around.
        always_comb begin
            cnt_d = '0;
            if ((state_d == state_q) && counting && !tick) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Full-width unsigned product of the sample and the current envelope.
        always_comb begin
            sample_ext = PROD_W'(in[k*DATA_W +: DATA_W]);
            env_ext    = PROD_W'(env_q);
            prod_d     = sample_ext * env_ext;
        end

        // Channel registers; asynchronous active-low reset returns the channel to IDLE.
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                env_q   <= '0;
                cnt_q   <= '0;
                prod_q  <= '0;
            end else begin
                state_q <= state_d;
                env_q   <= env_d;
                cnt_q   <= cnt_d;
                prod_q  <= prod_d;
            end
        end

        assign signal_out[k*PROD_W +: PROD_W] = prod_q;
        assign env_out[k*ENV_W +: ENV_W]      = env_q;
        assign active[k]                      = (state_q != ST_IDLE);

    end

endmodule
